ctrl_player: RTL and testbench

- Parametrised successor to the single-pad controller simulator used in the NES top-level bench.
- Models both NES controller ports with standard 8-bit shift-register pads, plus an optional Four Score 24-bit report mode.
- A frame-indexed button script in an internal RAM is loaded through a write port and replayed against a frame counter. This replaces hand-written per-frame button comparisons.
- Adds per-pad turbo on A/B. Sits between the nes core's ctrl_strobe/ctrl_out/ctrl_data pins and the bench or a board-level host.

---
 rtl/ctrl_player_pkg.sv | 35 +++
 rtl/ctrl_port_sr.sv | 58 +++++
 rtl/ctrl_player.sv | 158 +++++++++++++++
 tb/tb_ctrl_player.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_player_pkg.sv
// Shared types and constants for the NES controller player: button masks,
// script entry layout, replay FSM states and Four Score signatures.
package ctrl_player_pkg;

  localparam logic [7:0] BTN_A      = 8'h01;
  localparam logic [7:0] BTN_B      = 8'h02;
  localparam logic [7:0] BTN_SELECT = 8'h04;
  localparam logic [7:0] BTN_START  = 8'h08;
  localparam logic [7:0] BTN_UP     = 8'h10;
  localparam logic [7:0] BTN_DOWN   = 8'h20;
  localparam logic [7:0] BTN_LEFT   = 8'h40;
  localparam logic [7:0] BTN_RIGHT  = 8'h80;

  // Four Score signature bytes, shifted out LSB first after the two pads
  localparam logic [7:0] FS_SIG0 = 8'h08;
  localparam logic [7:0] FS_SIG1 = 8'h04;

  // Entry layout at the default frame width; a frame of all ones terminates
  localparam int SCRIPT_FRAME_W = 16;

  typedef struct packed {
    logic [SCRIPT_FRAME_W-1:0] frame;
    logic [1:0]                pad;
    logic [7:0]                btns;
  } script_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_WAIT,
    ST_DONE
  } replay_state_t;

endpackage

// File: rtl/ctrl_port_sr.sv
// One controller port: latches pad state while strobe is high and shifts it
// out on rising rd edges, in standard 8-bit or Four Score 24-bit form.
module ctrl_port_sr
  import ctrl_player_pkg::*;
#(
  parameter int PORT_ID  = 0,
  parameter bit FILL_BIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic       rd,
  input  logic       fourscore,
  input  logic [7:0] pad_lo,
  input  logic [7:0] pad_hi,
  output logic       data
);

  localparam logic [7:0]  SIG       = (PORT_ID == 0) ? FS_SIG0 : FS_SIG1;
  localparam logic [23:0] FILL_WORD = {24{FILL_BIT}};

  logic [23:0] sr;
  logic [23:0] sr_next;
  logic        rd_q;
  logic        strobe_q;
  logic        load;
  logic        shift;

  // An rd edge in the cycle strobe falls is swallowed so the latched A bit survives
  assign load  = strobe;
  assign shift = rd & ~rd_q & ~strobe & ~strobe_q;

  always_comb begin
    sr_next = sr;
    if (load) begin
      sr_next = fourscore ? {SIG, pad_hi, pad_lo} : {FILL_WORD[23:8], pad_lo};
    end else if (shift) begin
      sr_next = {FILL_BIT, sr[23:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= FILL_WORD;
      data     <= 1'b0;
      rd_q     <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sr       <= sr_next;
      rd_q     <= rd;
      strobe_q <= strobe;
      if (load || shift) begin
        data <= sr_next[0];
      end
    end
  end

endmodule

// File: rtl/ctrl_player.sv
// Two-port NES controller model with frame-indexed script replay, live
// button injection, per-pad A/B turbo and optional Four Score reports.
module ctrl_player
  import ctrl_player_pkg::*;
#(
  parameter int SCRIPT_DEPTH = 256,
  parameter int FRAME_W      = 16,
  parameter int TURBO_PERIOD = 2,
  parameter bit FILL_BIT     = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_tick,
  input  logic [1:0]                      strobe,
  input  logic [1:0]                      rd,
  output logic [1:0]                      data,
  input  logic                            fourscore,
  input  logic                            play_en,
  input  logic [15:0]                     turbo_mask,
  input  logic [31:0]                     btns_ext,
  input  logic                            wr_en,
  input  logic [$clog2(SCRIPT_DEPTH)-1:0] wr_addr,
  input  logic [FRAME_W+9:0]              wr_data,
  output logic [FRAME_W-1:0]              frame_cnt,
  output logic                            script_done,
  output logic [31:0]                     btns_cur
);

  localparam int AW = $clog2(SCRIPT_DEPTH);
  localparam int EW = FRAME_W + 10;
  localparam int TW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

  logic [EW-1:0]      mem [SCRIPT_DEPTH];
  logic [EW-1:0]      rd_word;
  logic [FRAME_W-1:0] rd_frame;
  logic [AW-1:0]      ptr;
  logic [3:0][7:0]    pad_state;
  logic               tick_pending;
  logic [TW-1:0]      turbo_cnt;
  logic               turbo_phase;
  logic [31:0]        eff;
  replay_state_t      state_q;
  replay_state_t      state_d;
  logic               apply;
  logic               hit_term;

  assign rd_frame = rd_word[EW-1:10];

  // Script RAM has no reset; the registered read gives the one-cycle FETCH latency
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (state_q == ST_FETCH) begin
      rd_word <= mem[ptr];
    end
  end

  always_comb begin
    state_d  = state_q;
    apply    = 1'b0;
    hit_term = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_CHECK;
      ST_CHECK: begin
        if (rd_frame == '1) begin
          state_d  = ST_DONE;
          hit_term = 1'b1;
        end else if (rd_frame <= frame_cnt) begin
          state_d = ST_FETCH;
          apply   = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT:  if (frame_tick || tick_pending) state_d = ST_FETCH;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    if (!play_en) begin
      state_d  = ST_IDLE;
      apply    = 1'b0;
      hit_term = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr          <= '0;
      pad_state    <= '0;
      script_done  <= 1'b0;
      tick_pending <= 1'b0;
      frame_cnt    <= '0;
      turbo_cnt    <= '0;
      turbo_phase  <= 1'b0;
      btns_cur     <= '0;
    end else begin
      state_q <= state_d;
      if (apply) begin
        pad_state[rd_word[9:8]] <= rd_word[7:0];
        ptr                     <= ptr + AW'(1);
      end
      if (hit_term) begin
        script_done <= 1'b1;
      end
      // Ticks seen outside WAIT are remembered so a frame is never skipped
      if (state_q == ST_WAIT && state_d == ST_FETCH) begin
        tick_pending <= 1'b0;
      end else if (frame_tick) begin
        tick_pending <= 1'b1;
      end
      if (frame_tick) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
        if (turbo_cnt == TW'(TURBO_PERIOD - 1)) begin
          turbo_cnt   <= '0;
          turbo_phase <= ~turbo_phase;
        end else begin
          turbo_cnt <= turbo_cnt + TW'(1);
        end
      end
      btns_cur <= eff;
    end
  end

  always_comb begin
    eff = btns_ext;
    for (int p = 0; p < 4; p++) begin
      eff[8*p +: 8] = pad_state[p] | btns_ext[8*p +: 8];
      eff[8*p]      = eff[8*p]     & ~(turbo_mask[2*p]     & turbo_phase);
      eff[8*p+1]    = eff[8*p+1]   & ~(turbo_mask[2*p+1]   & turbo_phase);
    end
  end

  ctrl_port_sr #(.PORT_ID(0), .FILL_BIT(FILL_BIT)) u_port0 (
    .clk       (clk),
    .rst       (rst),
    .strobe    (strobe[0]),
    .rd        (rd[0]),
    .fourscore (fourscore),
    .pad_lo    (btns_cur[7:0]),
    .pad_hi    (btns_cur[23:16]),
    .data      (data[0])
  );

  ctrl_port_sr #(.PORT_ID(1), .FILL_BIT(FILL_BIT)) u_port1 (
    .clk       (clk),
    .rst       (rst),
    .strobe    (strobe[1]),
    .rd        (rd[1]),
    .fourscore (fourscore),
    .pad_lo    (btns_cur[15:8]),
    .pad_hi    (btns_cur[31:24]),
    .data      (data[1])
  );

endmodule

// File: tb/tb_ctrl_player.sv
// Directed bench for ctrl_player: standard and Four Score reads, strobe
// boundaries, script replay, reset recovery and turbo.
module tb_ctrl_player;
  import ctrl_player_pkg::*;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic [1:0]  strobe;
  logic [1:0]  rd;
  logic [1:0]  data;
  logic        fourscore;
  logic        play_en;
  logic [15:0] turbo_mask;
  logic [31:0] btns_ext;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [25:0] wr_data;
  logic [15:0] frame_cnt;
  logic        script_done;
  logic [31:0] btns_cur;

  int vectors = 0;
  int errors  = 0;

  ctrl_player #(
    .SCRIPT_DEPTH (256),
    .FRAME_W      (16),
    .TURBO_PERIOD (2),
    .FILL_BIT     (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .strobe      (strobe),
    .rd          (rd),
    .data        (data),
    .fourscore   (fourscore),
    .play_en     (play_en),
    .turbo_mask  (turbo_mask),
    .btns_ext    (btns_ext),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_cnt   (frame_cnt),
    .script_done (script_done),
    .btns_cur    (btns_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rd(input logic [1:0] which);
    rd = which;
    applyStimulus(1);
    rd = 2'b00;
    applyStimulus(1);
  endtask

  task automatic pulse_strobe(input logic [1:0] which);
    strobe = which;
    applyStimulus(1);
    strobe = 2'b00;
    applyStimulus(1);
  endtask

  task automatic tick_frame();
    frame_tick = 1'b1;
    applyStimulus(1);
    frame_tick = 1'b0;
    applyStimulus(12);
  endtask

  task automatic write_entry(input logic [7:0] addr, input script_entry_t e);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = e;
    applyStimulus(1);
    wr_en   = 1'b0;
  endtask

  initial begin
    logic [10:0] std_exp;
    logic [25:0] fs0_exp;
    logic [25:0] fs1_exp;
    logic [5:0]  turbo_exp;

    std_exp   = 11'b111_0000_1001;
    fs0_exp   = 26'b11_00001000_00000100_00000001;
    fs1_exp   = 26'b11_00000100_00001000_00000010;
    turbo_exp = 6'b110011;

    rst = 1'b1; frame_tick = 1'b0; strobe = 2'b00; rd = 2'b00;
    fourscore = 1'b0; play_en = 1'b0; turbo_mask = 16'h0000;
    btns_ext = 32'h0; wr_en = 1'b0; wr_addr = 8'h00; wr_data = '0;
    applyStimulus(3);
    checkOutput("reset_data", 32'(data), 32'h0);
    checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'h0);
    checkOutput("reset_script_done", 32'(script_done), 32'h0);
    checkOutput("reset_btns_cur", btns_cur, 32'h0);
    rst = 1'b0;
    applyStimulus(1);

    // Standard 8-bit read of A+Start, followed by fill
    btns_ext = 32'h0000_0009;
    applyStimulus(2);
    pulse_strobe(2'b01);
    checkOutput("std_bit0", 32'(data[0]), 32'(std_exp[0]));
    for (int i = 1; i < 11; i++) begin
      pulse_rd(2'b01);
      checkOutput($sformatf("std_bit%0d", i), 32'(data[0]), 32'(std_exp[i]));
    end

    // rd during strobe is ignored; rd on the strobe-fall cycle does not shift
    strobe = 2'b01;
    applyStimulus(1);
    for (int i = 0; i < 3; i++) begin
      rd = 2'b01;
      applyStimulus(1);
      checkOutput($sformatf("rd_in_strobe%0d", i), 32'(data[0]), 32'h1);
      rd = 2'b00;
      applyStimulus(1);
    end
    strobe = 2'b00;
    rd     = 2'b01;
    applyStimulus(1);
    rd     = 2'b00;
    applyStimulus(1);
    checkOutput("fall_rd_noshift", 32'(data[0]), 32'h1);
    pulse_rd(2'b01);
    checkOutput("after_fall_B", 32'(data[0]), 32'h0);
    pulse_rd(2'b01);
    checkOutput("after_fall_Select", 32'(data[0]), 32'h0);
    pulse_rd(2'b01);
    checkOutput("after_fall_Start", 32'(data[0]), 32'h1);

    // Four Score 24-bit reports on both ports
    fourscore = 1'b1;
    btns_ext  = 32'h0804_0201;
    applyStimulus(2);
    pulse_strobe(2'b11);
    for (int i = 0; i < 26; i++) begin
      if (i > 0) pulse_rd(2'b11);
      checkOutput($sformatf("fs_port0_bit%0d", i), 32'(data[0]), 32'(fs0_exp[i]));
      checkOutput($sformatf("fs_port1_bit%0d", i), 32'(data[1]), 32'(fs1_exp[i]));
    end
    fourscore = 1'b0;
    btns_ext  = 32'h0;

    // Script replay: two pad0 entries on frame 3 (last wins), pad1 on frame 5
    write_entry(8'd0, '{frame: 16'd3,    pad: 2'd0, btns: 8'h08});
    write_entry(8'd1, '{frame: 16'd3,    pad: 2'd0, btns: 8'h80});
    write_entry(8'd2, '{frame: 16'd5,    pad: 2'd1, btns: 8'h01});
    write_entry(8'd3, '{frame: 16'hFFFF, pad: 2'd0, btns: 8'h00});
    play_en = 1'b1;
    applyStimulus(10);
    checkOutput("script_f0_btns", btns_cur, 32'h0);
    for (int f = 1; f <= 6; f++) begin
      tick_frame();
      checkOutput($sformatf("script_f%0d_frame_cnt", f), 32'(frame_cnt), 32'(f));
      checkOutput($sformatf("script_f%0d_pad0", f), 32'(btns_cur[7:0]), (f >= 3) ? 32'h80 : 32'h00);
      checkOutput($sformatf("script_f%0d_pad1", f), 32'(btns_cur[15:8]), (f >= 5) ? 32'h01 : 32'h00);
      checkOutput($sformatf("script_f%0d_done", f), 32'(script_done), (f >= 5) ? 32'h1 : 32'h0);
    end

    // Reset in the middle of a report, with replay enabled throughout
    btns_ext = 32'h0000_0009;
    applyStimulus(2);
    pulse_strobe(2'b01);
    pulse_rd(2'b01);
    checkOutput("pre_rst_B", 32'(data[0]), 32'h0);
    btns_ext = 32'h0;
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("rst_data", 32'(data), 32'h0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    checkOutput("rst_script_done", 32'(script_done), 32'h0);
    checkOutput("rst_btns_cur", btns_cur, 32'h0);
    rst = 1'b0;
    applyStimulus(10);
    checkOutput("restart_f0_btns", btns_cur, 32'h0);
    pulse_rd(2'b01);
    checkOutput("restart_fill", 32'(data[0]), 32'h1);
    for (int f = 1; f <= 3; f++) tick_frame();
    checkOutput("restart_f3_pad0", 32'(btns_cur[7:0]), 32'h80);
    checkOutput("restart_f3_done", 32'(script_done), 32'h0);

    // Turbo on pad0 A with a two-frame half period
    play_en = 1'b0;
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    btns_ext   = 32'h0000_0001;
    turbo_mask = 16'h0001;
    applyStimulus(3);
    for (int f = 0; f < 6; f++) begin
      checkOutput($sformatf("turbo_f%0d", f), 32'(btns_cur[0]), 32'(turbo_exp[f]));
      if (f < 5) tick_frame();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
